// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready ALU front end with registered RESULT and ZF/CF/SF/OF/ILL flags.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier; otherwise OP=111 reports ILL.
module alu_op_sequencer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             sf,
  output logic             of,
  output logic             ill
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             zf_r;
  logic             cf_r;
  logic             sf_r;
  logic             of_r;
  logic             ill_r;
  logic             res_valid_r;

  logic             accept_s;
  logic             exec_last_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_cf_s;
  logic             alu_of_s;
  logic             alu_ill_s;

  assign accept_s = (state_r == IDLE) && req_valid;
  assign sum_s    = {1'b0, a_r} + {1'b0, b_r};
  assign diff_s   = {1'b0, a_r} - {1'b0, b_r};

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_s;
  logic               mul_last_s;

  // Multiplier bits are consumed LSB first; the multiplicand walks left to weight each partial product.
  assign acc_s      = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
  assign mul_last_s = (cnt_r == CW'(WIDTH - 1));

  // Shift-add multiplier state: one partial product per EXEC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
    end else if ((state_r == EXEC) && (op_r == OP_MUL)) begin
      cnt_r    <= cnt_r + CW'(1);
      acc_r    <= acc_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else begin
      cnt_r    <= cnt_r;
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

  assign exec_last_s = (op_r != OP_MUL) || mul_last_s;
`else
  assign exec_last_s = 1'b1;
`endif

  // Operation decode on the latched operands
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_cf_s  = 1'b0;
    alu_of_s  = 1'b0;
    alu_ill_s = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_cf_s  = sum_s[WIDTH];
        alu_of_s  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_cf_s  = diff_s[WIDTH];
        alu_of_s  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND: alu_res_s = a_r & b_r;
      OP_OR:  alu_res_s = a_r | b_r;
      OP_XOR: alu_res_s = a_r ^ b_r;
      OP_SHL: begin
        alu_res_s = {a_r[WIDTH-2:0], 1'b0};
        alu_cf_s  = a_r[WIDTH-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, a_r[WIDTH-1:1]};
        alu_cf_s  = a_r[0];
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        alu_res_s = acc_s[WIDTH-1:0];
        alu_cf_s  = |acc_s[2*WIDTH-1:WIDTH];
        alu_of_s  = |acc_s[2*WIDTH-1:WIDTH];
`else
        alu_ill_s = 1'b1;
`endif
      end
      default: alu_ill_s = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = EXEC;
        else           state_s = IDLE;
      end
      EXEC: begin
        if (exec_last_s) state_s = DONE;
        else             state_s = EXEC;
      end
      DONE: begin
        if (res_valid_r && res_ready) state_s = IDLE;
        else                          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand latch and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      zf_r        <= 1'b0;
      cf_r        <= 1'b0;
      sf_r        <= 1'b0;
      of_r        <= 1'b0;
      ill_r       <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
      end
      if ((state_r == EXEC) && exec_last_s) begin
        result_r <= alu_res_s;
        zf_r     <= ~|alu_res_s;
        sf_r     <= alu_res_s[WIDTH-1];
        cf_r     <= alu_cf_s;
        of_r     <= alu_of_s;
        ill_r    <= alu_ill_s;
      end
      // Valid is presented from the second DONE cycle and drops on the transfer edge.
      res_valid_r <= (state_r == DONE) && !(res_valid_r && res_ready);
    end
  end

  assign req_ready = (state_r == IDLE);
  assign res_valid = res_valid_r;
  assign result    = result_r;
  assign zf        = zf_r;
  assign cf        = cf_r;
  assign sf        = sf_r;
  assign of        = of_r;
  assign ill       = ill_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer (WIDTH=6): the driver queues hand-computed expectations,
// a negedge monitor checks every presented result, its latency and its stability under backpressure.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int W = 6;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] SHL = 3'd5;
  localparam logic [2:0] SHR = 3'd6;
  localparam logic [2:0] MUL = 3'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         zf, cf, sf, of, ill;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zf;
    logic         cf;
    logic         sf;
    logic         of;
    logic         ill;
    logic [2:0]   op;
    logic [31:0]  acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   acc_seen = 0;
  logic prev_valid = 1'b0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .sf        (sf),
    .of        (of),
    .ill       (ill)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every presented response against the queue head, pop on transfer
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_seen++;
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb[0];
          if (!prev_valid)
            chk("latency", 32'(cyc), e.acc + ((e.op == MUL && MUL_EN) ? 32'(W + 1) : 32'd2));
          chk("result_flags", 32'({result, zf, cf, sf, of, ill}),
              32'({e.res, e.zf, e.cf, e.sf, e.of, e.ill}));
          if (res_ready) void'(sb.pop_front());
        end
      end
      prev_valid = res_valid;
    end
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] r, input logic z, input logic c, input logic s,
                      input logic v, input logic il);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    op = o; a = x; b = y; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
    end else begin
      e = '{res: r, zf: z, cf: c, sf: s, of: v, ill: il, op: o, acc: 32'(cyc + 1)};
      sb.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_cleared(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({name, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({name, "_result_flags"}, 32'({result, zf, cf, sf, of, ill}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; op = 3'd0; a = '0; b = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_cleared("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_cleared("post_reset");

    // Directed vectors, result/flags in order: res, zf, cf, sf, of, ill
    send(ADD, 6'd63, 6'd1,  6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(SUB, 6'd0,  6'd1,  6'd63, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(SUB, 6'd32, 6'd1,  6'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(ADD, 6'd31, 6'd1,  6'd32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(ADD, 6'd40, 6'd40, 6'd16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send(SUB, 6'd5,  6'd5,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(AND, 6'd5,  6'd3,  6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(OR,  6'd40, 6'd5,  6'd45, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(XOR, 6'd63, 6'd21, 6'd42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(XOR, 6'd9,  6'd9,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(SHL, 6'd33, 6'd0,  6'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(SHR, 6'd33, 6'd0,  6'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(SHR, 6'd2,  6'd0,  6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
    send(MUL, 6'd7,  6'd9,  6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(MUL, 6'd8,  6'd8,  6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send(MUL, 6'd5,  6'd5,  6'd25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    send(MUL, 6'd5,  6'd5,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(MUL, 6'd7,  6'd9,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    send(AND, 6'd5,  6'd3,  6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: hold the response while new requests are offered
    res_ready = 1'b0;
    send(SUB, 6'd0, 6'd1, 6'd63, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      op = AND; a = 6'(i + 10); b = 6'(63 - i); req_valid = 1'b1;
      @(negedge clk);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    res_ready = 1'b1;
    drain();

    // Reset in the middle of EXEC discards the operation
    res_ready = 1'b0;
`ifdef ALU_MUL_EN
    send(MUL, 6'd7, 6'd9, 6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
`else
    send(ADD, 6'd3, 6'd4, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    rst = 1'b1;
    sb.delete();
    #1;
    check_idle_cleared("abort_async");
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check_idle_cleared("abort_next");
    repeat (3) @(negedge clk);
    check_idle_cleared("abort_later");

    send(XOR, 6'd63, 6'd21, 6'd42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    chk("accept_count", 32'(acc_seen), 32'(pushed));
    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
